data_mem_unit: RTL and testbench

//   Multi-cycle data memory on the pipeline's MEM stage. Consumes adr_Mem, writeData_Mem,

---
 rtl/data_mem_unit.sv | 115 +++++++++++
 tb/tb_data_mem_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// data_mem_unit
//   Multi-cycle data memory for the MEM stage. It models a slow RAM with
//   WAIT_CYCLES programmable wait states and holds the pipeline through
//   `stall` until each access completes.
//
//   Ports
//     clk            in   rising-edge clock
//     rst            in   asynchronous, active-high reset
//     memRead        in   load request (held while stall=1)
//     memWrite       in   store request (held while stall=1), wins over memRead
//     adr_Mem        in   32-bit byte address, word index = adr_Mem[DEPTH_LOG2+1:2]
//     writeData_Mem  in   32-bit store data
//     readData_Mem   out  registered load data, updated only by completed loads
//     stall          out  high while a request is pending in IDLE or WAIT
//     misalign       out  one-cycle pulse in DONE when adr_Mem[1:0] != 0
module data_mem_unit #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] adr_Mem,
  input  logic [31:0] writeData_Mem,
  output logic [31:0] readData_Mem,
  output logic        stall,
  output logic        misalign
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [31:0]             rdata_q;
  logic                    misalign_q;
  logic                    req;
  logic                    access;
  logic [DEPTH_LOG2-1:0]   idx;
  logic [31:0]             mem [DEPTH];

  // Address bits above the array are ignored, so addresses wrap modulo DEPTH.
  logic unused_adr_hi;
  assign unused_adr_hi = ^adr_Mem[31:DEPTH_LOG2+2];

  assign req = memRead | memWrite;
  assign idx = adr_Mem[DEPTH_LOG2+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d   = WAIT_CNT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A dropped request means the pipeline flushed this instruction.
        if (!req) begin
          state_d = S_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      rdata_q    <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_q <= access & (adr_Mem[1:0] != 2'b00);
      if (access && !memWrite) begin
        rdata_q <= mem[idx];
      end
    end
  end

  // Array is deliberately not reset; the rst gate keeps a reset that lands on
  // the access edge from committing the store.
  always_ff @(posedge clk) begin
    if (access && memWrite && !rst) begin
      mem[idx] <= writeData_Mem;
    end
  end

  assign stall        = req & ((state_q == S_IDLE) | (state_q == S_WAIT));
  assign readData_Mem = rdata_q;
  assign misalign     = misalign_q;

endmodule

// File: tb/tb_data_mem_unit.sv
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mr  [2];
  logic        mw  [2];
  logic [31:0] adr [2];
  logic [31:0] wd  [2];
  logic [31:0] rdo [2];
  logic        st  [2];
  logic        mis [2];

  int checks   = 0;
  int failures = 0;

  // Reference state: word contents keyed by unit*1024 + word index, plus last load.
  logic [31:0] model_mem [int];
  logic [31:0] model_rd  [2];

  always #5 clk = ~clk;

  // Unit 0: WAIT_CYCLES=2, unit 1: WAIT_CYCLES=0.
  data_mem_unit #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .memRead(mr[0]), .memWrite(mw[0]),
    .adr_Mem(adr[0]), .writeData_Mem(wd[0]), .readData_Mem(rdo[0]),
    .stall(st[0]), .misalign(mis[0])
  );

  data_mem_unit #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .memRead(mr[1]), .memWrite(mw[1]),
    .adr_Mem(adr[1]), .writeData_Mem(wd[1]), .readData_Mem(rdo[1]),
    .stall(st[1]), .misalign(mis[1])
  );

  function automatic int key_of(input int u, input logic [31:0] a);
    return u * 1024 + int'(a[11:2]);
  endfunction

  // Issue one request, hold it until stall drops, check the DONE cycle, release.
  task automatic do_access(input int u, input bit r, input bit w,
                           input logic [31:0] a, input logic [31:0] d,
                           input string nm);
    int  n;
    int  exp_n;
    bit  done;
    int  k;
    n     = 0;
    done  = 0;
    exp_n = ((u == 0) ? 2 : 0) + 2;
    k     = key_of(u, a);
    mr[u] = r; mw[u] = w; adr[u] = a; wd[u] = d;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (st[u]) begin
        n++;
        checks++;
        if (rdo[u] !== model_rd[u]) begin
          failures++;
          $display("FAIL %s hold_during_stall: got %h want %h", nm, rdo[u], model_rd[u]);
        end
        @(posedge clk); #1;
      end else begin
        done = 1;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout: stall never dropped after %0d cycles", nm, n);
    end
    if (w) model_mem[k] = d;
    else if (model_mem.exists(k)) model_rd[u] = model_mem[k];
    checks++;
    if (n != exp_n) begin
      failures++;
      $display("FAIL %s stall_cycles: got %0d want %0d", nm, n, exp_n);
    end
    checks++;
    if (rdo[u] !== model_rd[u]) begin
      failures++;
      $display("FAIL %s readData: got %h want %h", nm, rdo[u], model_rd[u]);
    end
    checks++;
    if (mis[u] !== (a[1:0] != 2'b00)) begin
      failures++;
      $display("FAIL %s misalign: got %b want %b", nm, mis[u], (a[1:0] != 2'b00));
    end
    mr[u] = 0; mw[u] = 0;
    @(posedge clk); #1;
    checks++;
    if (mis[u] !== 1'b0 || st[u] !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done: misalign=%b stall=%b want 0 0", nm, mis[u], st[u]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      mr[u] = 0; mw[u] = 0; adr[u] = 0; wd[u] = 0; model_rd[u] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (rdo[u] !== 32'd0 || st[u] !== 1'b0 || mis[u] !== 1'b0) begin
        failures++;
        $display("FAIL reset_u%0d: rd=%h stall=%b mis=%b want 0 0 0", u, rdo[u], st[u], mis[u]);
      end
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    do_access(0, 0, 1, 32'h40, 32'hDEADBEEF, "store_40");
    do_access(0, 1, 0, 32'h40, 32'h0, "load_40");
  endtask

  task automatic test_read_write_both();
    do_access(0, 1, 1, 32'h80, 32'h12345678, "both_80");
    do_access(0, 1, 0, 32'h80, 32'h0, "load_80");
  endtask

  task automatic test_wrap_misalign();
    do_access(0, 0, 1, 32'h1000, 32'h1, "store_1000");
    do_access(0, 1, 0, 32'h0, 32'h0, "load_0_wrap");
    do_access(0, 1, 0, 32'h43, 32'h0, "load_43_mis");
  endtask

  task automatic test_abort(input bit use_rst);
    string nm;
    nm = use_rst ? "abort_rst" : "abort_flush";
    do_access(0, 0, 1, 32'hC0, 32'hA5A50000 + (use_rst ? 32'h1 : 32'h0), {nm, "_pre"});
    mw[0] = 1; adr[0] = 32'hC0; wd[0] = 32'h0BADF00D;
    @(posedge clk); #1;   // first WAIT cycle
    @(posedge clk); #1;   // second WAIT cycle
    checks++;
    if (st[0] !== 1'b1) begin
      failures++;
      $display("FAIL %s stall_in_wait: got %b want 1", nm, st[0]);
    end
    if (use_rst) begin
      rst = 1'b1; mw[0] = 0;
      model_rd[0] = 0; model_rd[1] = 0;
      #1;
      checks++;
      if (rdo[0] !== 32'd0) begin
        failures++;
        $display("FAIL %s rd_cleared: got %h want 0", nm, rdo[0]);
      end
      @(negedge clk); rst = 1'b0;
    end else begin
      mw[0] = 0;
    end
    @(posedge clk); #1;
    checks++;
    if (st[0] !== 1'b0 || rdo[0] !== model_rd[0]) begin
      failures++;
      $display("FAIL %s after_abort: stall=%b rd=%h want 0 %h", nm, st[0], rdo[0], model_rd[0]);
    end
    // A fresh load must take the full latency and see the pre-abort word.
    do_access(0, 1, 0, 32'hC0, 32'h0, {nm, "_load"});
  endtask

  task automatic test_random();
    int idxs [6];
    for (int i = 0; i < 6; i++) idxs[i] = int'($urandom_range(1023, 0));
    for (int it = 0; it < 30; it++) begin
      int          sel;
      logic [31:0] a;
      int          op;
      sel = int'($urandom_range(5, 0));
      a   = ($urandom & 32'hFFFF_F000) | (32'(idxs[sel]) << 2) | ($urandom & 32'h3);
      op  = int'($urandom_range(2, 0));
      if (!model_mem.exists(key_of(0, a))) op = 1;
      case (op)
        0:       do_access(0, 1, 0, a, $urandom, "rand_load");
        1:       do_access(0, 0, 1, a, $urandom, "rand_store");
        default: do_access(0, 1, 1, a, $urandom, "rand_both");
      endcase
    end
  endtask

  task automatic test_back_to_back();
    bit          exp_st [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] va, vb;
    va = $urandom; vb = $urandom;
    do_access(1, 0, 1, 32'h40, va, "b2b_pre40");
    do_access(1, 0, 1, 32'h80, vb, "b2b_pre80");
    // W=0: cycles are IDLE, WAIT, DONE, IDLE, WAIT, DONE with stall 1,1,0,1,1,0.
    exp_st = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    mr[1] = 1; adr[1] = 32'h40;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (st[1] !== exp_st[c]) begin
        failures++;
        $display("FAIL b2b_stall_c%0d: got %b want %b", c, st[1], exp_st[c]);
      end
      if (c == 2 || c == 3) begin
        checks++;
        if (rdo[1] !== va) begin
          failures++;
          $display("FAIL b2b_first_c%0d: got %h want %h", c, rdo[1], va);
        end
      end
      if (c == 5) begin
        checks++;
        if (rdo[1] !== vb) begin
          failures++;
          $display("FAIL b2b_second: got %h want %h", rdo[1], vb);
        end
      end
      if (c == 2) adr[1] = 32'h80;
      if (c == 5) mr[1] = 0;
      @(posedge clk); #1;
    end
    model_rd[1] = vb;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_read_write_both();
    test_wrap_misalign();
    test_abort(1'b0);
    test_abort(1'b1);
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
